// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL lock qualification and ordered fabric/core reset release
// Optional feature macro: RSTSEQ_SW_RESET_EN adds SW_RESET for a core-only re-reset from RUN.
module pll_lock_reset_seq #(
  parameter int LOCK_SYNC_STAGES   = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int FAB_TO_CORE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
`ifdef RSTSEQ_SW_RESET_EN
  input  logic       SW_RESET,
`endif
  output logic       FABRIC_RESET_N,
  output logic       CORE_RESET_N,
  output logic       READY,
  output logic [7:0] LOCK_LOSS_CNT
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > FAB_TO_CORE_CYCLES) ?
                           LOCK_STABLE_CYCLES : FAB_TO_CORE_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] FAB_LAST    = CW'(FAB_TO_CORE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STABLE, FAB_REL, RUN} state_t;

  state_t                      state, state_nx;
  logic [CW-1:0]               cnt, cnt_nx;
  logic [LOCK_SYNC_STAGES-1:0] sync;
  logic                        lock_s;
  logic                        sw_req;

  assign lock_s = sync[LOCK_SYNC_STAGES-1];

`ifdef RSTSEQ_SW_RESET_EN
  assign sw_req = SW_RESET;
`else
  assign sw_req = 1'b0;
`endif

  // Every non-IDLE state falls back to IDLE on loss of lock before anything else.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (lock_s) state_nx = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nx = FAB_REL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FAB_REL: begin
        if (!lock_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == FAB_LAST) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (sw_req) begin
          state_nx = FAB_REL;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync           <= '0;
      state          <= IDLE;
      cnt            <= '0;
      LOCK_LOSS_CNT  <= '0;
      FABRIC_RESET_N <= 1'b0;
      CORE_RESET_N   <= 1'b0;
      READY          <= 1'b0;
    end else begin
      sync           <= {sync[LOCK_SYNC_STAGES-2:0], PLL_LOCK};
      state          <= state_nx;
      cnt            <= cnt_nx;
      if (state == RUN && !lock_s && LOCK_LOSS_CNT != 8'hFF)
        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
      FABRIC_RESET_N <= (state_nx == FAB_REL) || (state_nx == RUN);
      CORE_RESET_N   <= (state_nx == RUN);
      READY          <= (state_nx == RUN);
    end
  end

endmodule
